// File: rtl/l2_latency_model.sv
// l2_latency_model: word-addressed L2 stand-in with a fixed, programmable access latency
module l2_latency_model #(
  parameter int          MEM_WORDS = 1024,
  parameter int          LATENCY   = 4,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter logic [31:0] ERR_DATA  = 32'hBAD1_BAD1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        l2REN,
  input  logic        l2WEN,
  input  logic [31:0] l2addr,
  input  logic [31:0] l2store,
  input  logic [3:0]  l2_byte_en,
  output logic [31:0] l2load,
  output logic [1:0]  l2state
);
  localparam int AW = $clog2(MEM_WORDS);
  typedef enum logic [1:0] {L2_FREE, L2_BUSY, L2_ACCESS, L2_ERROR} state_t;
  state_t state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0] store_q, store_d;
  logic [3:0] be_q, be_d;
  logic wr_q, wr_d;
  logic [31:0] load_q, load_d;
  logic [31:0] mem [MEM_WORDS];
  logic [29:0] off;
  logic bad, go, we, free;
  logic [AW-1:0] cur_idx;
  logic [31:0] cur_store, rd, merged;
  logic [3:0] cur_be;
  logic cur_wr;
  assign off = l2addr[31:2] - BASE_ADDR[31:2];
  assign bad = (l2REN && l2WEN) || (l2addr[1:0] != 2'd0) || (l2addr < BASE_ADDR) || ({2'b0, off} >= 32'(MEM_WORDS));
  assign free = state_q == L2_FREE;
  // In FREE the access may complete on the sampling edge, so use live inputs; otherwise the latched copy
  always_comb begin
    cur_idx = free ? off[AW-1:0] : idx_q;
    cur_store = free ? l2store : store_q;
    cur_be = free ? l2_byte_en : be_q;
    cur_wr = free ? l2WEN : wr_q;
    rd = mem[cur_idx];
    merged = rd;
    for (int i = 0; i < 4; i++)
      merged[8*i+:8] = (cur_wr && cur_be[i]) ? cur_store[8*i+:8] : rd[8*i+:8];
  end
  // Next-state, latch and load update; go marks entry into ACCESS
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    store_d = store_q;
    be_d = be_q;
    wr_d = wr_q;
    load_d = load_q;
    go = 1'b0;
    case (state_q)
      L2_FREE: if (l2REN || l2WEN) begin
        idx_d = off[AW-1:0];
        store_d = l2store;
        be_d = l2_byte_en;
        wr_d = l2WEN;
        if (bad) begin
          state_d = L2_ERROR;
          load_d = ERR_DATA;
        end else if (LATENCY == 0) go = 1'b1;
        else begin
          state_d = L2_BUSY;
          cnt_d = 32'(LATENCY - 1);
        end
      end
      L2_BUSY: if (!l2REN && !l2WEN) state_d = L2_FREE;
        else if (cnt_q == 32'd0) go = 1'b1;
        else cnt_d = cnt_q - 32'd1;
      default: state_d = L2_FREE;
    endcase
    if (go) begin
      state_d = L2_ACCESS;
      load_d = merged;
    end
  end
  assign we = go && cur_wr && !RST;
  // Control and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= L2_FREE;
      cnt_q <= '0;
      idx_q <= '0;
      store_q <= '0;
      be_q <= '0;
      wr_q <= 1'b0;
      load_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      store_q <= store_d;
      be_q <= be_d;
      wr_q <= wr_d;
      load_q <= load_d;
    end
  end
  // Backing array, not reset; written only on entry into ACCESS for a write
  always_ff @(posedge CLK) begin
    if (we) mem[cur_idx] <= merged;
  end
  assign l2load = load_q;
  assign l2state = state_q;
endmodule

// File: tb/tb_l2_latency_model.sv
// tb_l2_latency_model: directed table-driven checks of l2_latency_model
module tb_l2_latency_model;
  localparam int LAT = 4;
  localparam logic [1:0] FR = 2'd0, BS = 2'd1, AC = 2'd2, ER = 2'd3;
  localparam logic [31:0] B = 32'h8000_0000, ERRD = 32'hBAD1_BAD1;
  logic CLK = 1'b0, RST;
  logic ren, wen;
  logic [31:0] addr, store;
  logic [3:0] be;
  logic [31:0] ld, ld0;
  logic [1:0] st, st0;
  int checks = 0, errors = 0;
  logic [31:0] last_ld;
  typedef struct {
    logic ren, wen;
    logic [31:0] addr, store;
    logic [3:0] be;
    logic [1:0] st;
    logic [31:0] ld;
  } vec_t;
  vec_t tbl[$];
  always #5 CLK = ~CLK;
  l2_latency_model #(.LATENCY(LAT)) dut (
    .CLK(CLK), .RST(RST), .l2REN(ren), .l2WEN(wen), .l2addr(addr), .l2store(store),
    .l2_byte_en(be), .l2load(ld), .l2state(st));
  l2_latency_model #(.LATENCY(0)) dut0 (
    .CLK(CLK), .RST(RST), .l2REN(ren), .l2WEN(wen), .l2addr(addr), .l2store(store),
    .l2_byte_en(be), .l2load(ld0), .l2state(st0));
  task automatic step(input logic sel, input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] s, input logic [3:0] b, input logic [1:0] est,
                      input logic [31:0] eld, input string name);
    logic [1:0] ast;
    logic [31:0] ald;
    ren = r; wen = w; addr = a; store = s; be = b;
    @(posedge CLK);
    #1;
    ast = sel ? st0 : st;
    ald = sel ? ld0 : ld;
    checks += 2;
    if (ast !== est) begin
      errors++;
      $display("FAIL %s state got %0d want %0d", name, ast, est);
    end
    if (ald !== eld) begin
      errors++;
      $display("FAIL %s load got %h want %h", name, ald, eld);
    end
  endtask
  task automatic add_txn(input logic r, input logic w, input logic [31:0] a, input logic [31:0] s,
                         input logic [3:0] b, input logic err, input logic [31:0] eld);
    if (err) tbl.push_back('{r, w, a, s, b, ER, ERRD});
    else begin
      for (int i = 0; i < LAT; i++) tbl.push_back('{r, w, a, s, b, BS, last_ld});
      tbl.push_back('{r, w, a, s, b, AC, eld});
    end
    last_ld = err ? ERRD : eld;
    tbl.push_back('{1'b0, 1'b0, 32'h0, 32'h0, 4'h0, FR, last_ld});
  endtask
  task automatic run_tbl(input string tag);
    foreach (tbl[i])
      step(1'b0, tbl[i].ren, tbl[i].wen, tbl[i].addr, tbl[i].store, tbl[i].be, tbl[i].st, tbl[i].ld,
           $sformatf("%s[%0d]", tag, i));
    tbl.delete();
  endtask
  initial begin
    RST = 1'b1; ren = 0; wen = 0; addr = 0; store = 0; be = 0;
    @(posedge CLK);
    #1;
    checks += 2;
    if (st !== FR) begin errors++; $display("FAIL reset state got %0d want 0", st); end
    if (ld !== 32'h0) begin errors++; $display("FAIL reset load got %h want 0", ld); end
    RST = 1'b0;
    last_ld = 32'h0;
    add_txn(0, 1, B + 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'hDEADBEEF);
    add_txn(1, 0, B + 32'h10, 32'h0, 4'h0, 0, 32'hDEADBEEF);
    add_txn(0, 1, B + 32'h20, 32'h11223344, 4'hF, 0, 32'h11223344);
    add_txn(0, 1, B + 32'h20, 32'hAABBCCDD, 4'b0101, 0, 32'h11BB33DD);
    add_txn(1, 0, B + 32'h20, 32'h0, 4'h0, 0, 32'h11BB33DD);
    add_txn(1, 0, 32'h7FFF_FFFC, 32'h0, 4'h0, 1, 32'h0);
    add_txn(1, 0, 32'h8000_1000, 32'h0, 4'h0, 1, 32'h0);
    add_txn(1, 0, 32'h8000_0002, 32'h0, 4'h0, 1, 32'h0);
    add_txn(1, 1, B + 32'h10, 32'h0, 4'hF, 1, 32'h0);
    add_txn(1, 0, B + 32'h10, 32'h0, 4'h0, 0, 32'hDEADBEEF);
    add_txn(0, 1, 32'h8000_0FFC, 32'h12345678, 4'hF, 0, 32'h12345678);
    add_txn(1, 0, 32'h8000_0FFC, 32'h0, 4'h0, 0, 32'h12345678);
    add_txn(0, 1, B + 32'h30, 32'hCAFEF00D, 4'hF, 0, 32'hCAFEF00D);
    add_txn(0, 1, B + 32'h30, 32'hFFFFFFFF, 4'h0, 0, 32'hCAFEF00D);
    add_txn(1, 0, B + 32'h30, 32'h0, 4'h0, 0, 32'hCAFEF00D);
    run_tbl("tbl");
    step(0, 0, 1, B + 32'h30, 32'h0, 4'hF, BS, 32'hCAFEF00D, "abort_b1");
    step(0, 0, 1, B + 32'h30, 32'h0, 4'hF, BS, 32'hCAFEF00D, "abort_b2");
    step(0, 0, 0, B + 32'h30, 32'h0, 4'hF, FR, 32'hCAFEF00D, "abort_free");
    add_txn(1, 0, B + 32'h30, 32'h0, 4'h0, 0, 32'hCAFEF00D);
    run_tbl("abort_rd");
    step(0, 0, 1, B + 32'h30, 32'h0, 4'hF, BS, 32'hCAFEF00D, "rst_b1");
    step(0, 0, 1, B + 32'h30, 32'h0, 4'hF, BS, 32'hCAFEF00D, "rst_b2");
    step(0, 0, 1, B + 32'h30, 32'h0, 4'hF, BS, 32'hCAFEF00D, "rst_b3");
    RST = 1'b1;
    step(0, 0, 1, B + 32'h30, 32'h0, 4'hF, FR, 32'h0, "rst_edge");
    RST = 1'b0;
    last_ld = 32'h0;
    add_txn(1, 0, B + 32'h30, 32'h0, 4'h0, 0, 32'hCAFEF00D);
    run_tbl("rst_rd");
    step(1, 0, 1, B + 32'h40, 32'h13579BDF, 4'hF, AC, 32'h13579BDF, "l0_wr");
    step(1, 0, 0, B + 32'h40, 32'h0, 4'h0, FR, 32'h13579BDF, "l0_wr_free");
    step(1, 1, 0, B + 32'h40, 32'h0, 4'h0, AC, 32'h13579BDF, "l0_rd1");
    step(1, 1, 0, B + 32'h40, 32'h0, 4'h0, FR, 32'h13579BDF, "l0_rd1_free");
    step(1, 1, 0, B + 32'h40, 32'h0, 4'h0, AC, 32'h13579BDF, "l0_rd2");
    step(1, 0, 0, B + 32'h40, 32'h0, 4'h0, FR, 32'h13579BDF, "l0_rd2_free");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
